// File: rtl/bram_fifo_if.sv
// bram_fifo_if: write/read handshake and status bundle for bram_fifo.
// master drives wd/wr/rd; slave returns data, flags and occupancy.
interface bram_fifo_if #(
    parameter int WIDTH      = 36,
    parameter int DEPTH_LOG2 = 10
);
    logic [WIDTH-1:0]    wd;
    logic                wr;
    logic                full;
    logic                afull;
    logic                rd;
    logic [WIDTH-1:0]    rdata;
    logic                rvalid;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                underflow;

    modport master (
        output wd, wr, rd,
        input  full, afull, rdata, rvalid, empty, count, overflow, underflow
    );

    modport slave (
        input  wd, wr, rd,
        output full, afull, rdata, rvalid, empty, count, overflow, underflow
    );
endinterface

// File: rtl/bram_fifo.sv
// bram_fifo: single-clock FIFO on an inferred simple dual-port RAM, with
// count, full/empty/afull, sticky overflow/underflow.
// Ports: clk, reset (async, active-high), bus (bram_fifo_if.slave).
// Define BRAM_FIFO_FWFT_EN for a first-word-fall-through output stage.
module bram_fifo #(
    parameter int WIDTH       = 36,
    parameter int DEPTH_LOG2  = 10,
    parameter int AFULL_LEVEL = 1008
) (
    input logic        clk,
    input logic        reset,
    bram_fifo_if.slave bus
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic full, empty, wr_ok, pop, ram_rd, ram_ne;

    assign full   = (count_q == DEPTH_C);
    assign ram_ne = (wptr_q != rptr_q);
    assign wr_ok  = bus.wr && !full;
    assign pop    = bus.rd && !empty;

`ifdef BRAM_FIFO_FWFT_EN
    logic head_q, head_d;

    // The output register is the head; refill it whenever it is
    // vacant or being popped, so streaming pops see no bubble.
    assign empty  = !head_q;
    assign ram_rd = ram_ne && (!head_q || pop);

    always_comb begin
        head_d = ram_rd || (head_q && !pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) head_q <= 1'b0;
        else       head_q <= head_d;
    end

    assign bus.rvalid = 1'b0;
`else
    logic rvalid_q;

    assign empty  = !ram_ne;
    assign ram_rd = pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rvalid_q <= 1'b0;
        else       rvalid_q <= pop;
    end

    assign bus.rvalid = rvalid_q;
`endif

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_q[DEPTH_LOG2-1:0]] <= bus.wd;
    end

    always_comb begin
        wptr_d  = wptr_q + PW'(wr_ok);
        rptr_d  = rptr_q + PW'(ram_rd);
        rdata_d = rdata_q;
        if (ram_rd) rdata_d = mem[rptr_q[DEPTH_LOG2-1:0]];
        ovf_d   = ovf_q || (bus.wr && full);
        udf_d   = udf_q || (bus.rd && empty);
        count_d = count_q;
        unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.full      = full;
    assign bus.afull     = (count_q >= AFULL_C);
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.rdata     = rdata_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule
